// File: rtl/dct_mac_pkg.sv
// Shared defaults and width helpers for the DCT accumulator slice.
package dct_mac_pkg;

   localparam int PROD_W_DEF     = 24;
   localparam int N_TAPS_DEF     = 8;
   localparam int FRAC_SHIFT_DEF = 13;
   localparam int OUT_W_DEF      = 11;

   // Half an output LSB, added before the arithmetic shift.
   localparam int ROUND_DEF = 1 << (FRAC_SHIFT_DEF - 1);

   // Wide enough that N_TAPS full-scale products never overflow.
   function automatic int acc_width(input int prod_w, input int n_taps);
      return prod_w + $clog2(n_taps);
   endfunction

endpackage

// File: rtl/dct_round_sat.sv
// Rounds half toward +inf, drops the fractional bits and reduces to OUT_W.
// Clamping and the sat flag exist only when DCT_MAC_SAT_EN is defined.
module dct_round_sat
   import dct_mac_pkg::*;
#(
   parameter int ACC_W      = acc_width(PROD_W_DEF, N_TAPS_DEF),
   parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
   parameter int OUT_W      = OUT_W_DEF,
   parameter int ROUND      = ROUND_DEF
) (
   input  logic signed [ACC_W-1:0] sum,
   output logic signed [OUT_W-1:0] r,
   output logic                    sat
);

   // One guard bit so the rounding add cannot overflow at full scale.
   localparam int RW = ACC_W + 1;
   localparam logic signed [RW-1:0] ROUND_C = RW'(ROUND);

   logic signed [RW-1:0] rounded;

   assign rounded = {sum[ACC_W-1], sum} + ROUND_C;

`ifdef DCT_MAC_SAT_EN
   localparam logic signed [RW-1:0] MAX_V = RW'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

   logic signed [RW-1:0] shifted;

   assign shifted = rounded >>> FRAC_SHIFT;

   // NOTE: every output of a combinational block is defaulted first, so no
   // path through the if/else can leave a latch behind.
   always_comb begin
      r   = shifted[OUT_W-1:0];
      sat = 1'b0;
      if (shifted > MAX_V) begin
         r   = MAX_V[OUT_W-1:0];
         sat = 1'b1;
      end else if (shifted < MIN_V) begin
         r   = MIN_V[OUT_W-1:0];
         sat = 1'b1;
      end
   end
`else
   assign r   = OUT_W'(rounded >>> FRAC_SHIFT);
   assign sat = 1'b0;
`endif

endmodule

// File: rtl/dct_mac_acc.sv
// Sums N_TAPS signed products into one DCT coefficient behind a valid/ready
// output register. Define DCT_MAC_SAT_EN to clamp instead of wrap.
module dct_mac_acc
   import dct_mac_pkg::*;
#(
   parameter int PROD_W     = PROD_W_DEF,
   parameter int N_TAPS     = N_TAPS_DEF,
   parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
   parameter int OUT_W      = OUT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [PROD_W-1:0] in_prod,
   input  logic                     acc_clr,
   output logic                     coef_valid,
   input  logic                     coef_ready,
   output logic signed [OUT_W-1:0]  coef_data,
   output logic                     coef_sat,
   output logic                     busy
);

   localparam int ACC_W = acc_width(PROD_W, N_TAPS);
   localparam int CNT_W = $clog2(N_TAPS);

   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] sum;
   logic signed [OUT_W-1:0] r;
   logic                    r_sat;
   logic                    last;
   logic                    accept;
   logic                    fire;

   assign prod_ext = {{(ACC_W - PROD_W){in_prod[PROD_W-1]}}, in_prod};
   assign sum      = acc + prod_ext;
   assign last     = (cnt == CNT_W'(N_TAPS - 1));
   assign busy     = (cnt != '0);

   // Only the final product of a group waits for the output register.
   assign in_ready = !(last && coef_valid && !coef_ready);
   assign accept   = in_valid && in_ready;
   assign fire     = accept && last && !acc_clr;

   dct_round_sat #(
      .ACC_W      (ACC_W),
      .FRAC_SHIFT (FRAC_SHIFT),
      .OUT_W      (OUT_W),
      .ROUND      (2 ** (FRAC_SHIFT - 1))
   ) u_round_sat (
      .sum (sum),
      .r   (r),
      .sat (r_sat)
   );

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         acc <= '0;
      end else if (acc_clr) begin
         if (accept) begin
            cnt <= CNT_W'(1);
            acc <= prod_ext;
         end else begin
            cnt <= '0;
            acc <= '0;
         end
      end else if (accept) begin
         acc <= (cnt == '0) ? prod_ext : sum;
         cnt <= last ? '0 : cnt + 1'b1;
      end
   end

   // A drain and a reload in the same cycle keep coef_valid high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         coef_valid <= 1'b0;
         coef_data  <= '0;
         coef_sat   <= 1'b0;
      end else if (fire) begin
         coef_valid <= 1'b1;
         coef_data  <= r;
         coef_sat   <= r_sat;
      end else if (coef_valid && coef_ready) begin
         coef_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dct_mac_acc.sv
// Directed and randomized checks of dct_mac_acc against a queue-based model.
// Expectations follow DCT_MAC_SAT_EN the same way the design does.
module tb_dct_mac_acc;

   localparam int PROD_W     = 24;
   localparam int N_TAPS     = 8;
   localparam int FRAC_SHIFT = 13;
   localparam int OUT_W      = 11;

   logic                     clk;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [PROD_W-1:0] in_prod;
   logic                     acc_clr;
   logic                     coef_valid;
   logic                     coef_ready;
   logic signed [OUT_W-1:0]  coef_data;
   logic                     coef_sat;
   logic                     busy;

   int n_checks = 0;
   int n_fail   = 0;

   dct_mac_acc #(
      .PROD_W     (PROD_W),
      .N_TAPS     (N_TAPS),
      .FRAC_SHIFT (FRAC_SHIFT),
      .OUT_W      (OUT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_prod    (in_prod),
      .acc_clr    (acc_clr),
      .coef_valid (coef_valid),
      .coef_ready (coef_ready),
      .coef_data  (coef_data),
      .coef_sat   (coef_sat),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {sat, data} for a finished sum: floor((sum + half) / 2^F).
   function automatic logic [OUT_W:0] ref_coef(input longint sum);
      longint     den;
      longint     t;
      longint     q;
      logic [63:0] bits;
      logic        s;
      den = longint'(1) << FRAC_SHIFT;
      t   = sum + den / 2;
      q   = (t >= 0) ? t / den : -((-t + den - 1) / den);
      s   = 1'b0;
`ifdef DCT_MAC_SAT_EN
      if (q > (longint'(1) << (OUT_W - 1)) - 1) begin
         q = (longint'(1) << (OUT_W - 1)) - 1;
         s = 1'b1;
      end else if (q < -(longint'(1) << (OUT_W - 1))) begin
         q = -(longint'(1) << (OUT_W - 1));
         s = 1'b1;
      end
`endif
      bits = 64'(q);
      return {s, bits[OUT_W-1:0]};
   endfunction

   task automatic do_reset();
      rst        = 1'b0;
      in_valid   = 1'b0;
      in_prod    = '0;
      acc_clr    = 1'b0;
      coef_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // One product per cycle; leaves the bench at 1 ns after the last edge.
   task automatic send_n(input int n, input int prod);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_prod  = PROD_W'(prod);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b0;
      #2;
      n_checks++;
      if ({coef_valid, coef_sat, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got valid=%b sat=%b busy=%b, want 0 0 0", coef_valid, coef_sat, busy);
      end
      n_checks++;
      if (coef_data !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %0d, want 0", coef_data);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b, want 1", in_ready);
      end
      do_reset();
   endtask

   task automatic test_basic();
      do_reset();
      send_n(N_TAPS - 1, 1024);
      n_checks++;
      if (coef_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_partial: got valid=%b busy=%b, want 0 1", coef_valid, busy);
      end
      send_n(1, 1024);
      n_checks++;
      if (coef_valid !== 1'b1 || coef_data !== 11'sd1 || coef_sat !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_coef: got valid=%b data=%0d sat=%b, want 1 1 0", coef_valid, coef_data, coef_sat);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_busy: got %b, want 0", busy);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (coef_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_drain: got valid=%b, want 0", coef_valid);
      end
   endtask

   task automatic test_rounding();
      int prods [3];
      int want  [3];
      prods = '{512, -512, 4096};
      want  = '{1, 0, 4};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         send_n(N_TAPS, prods[k]);
         n_checks++;
         if (coef_valid !== 1'b1 || coef_data !== OUT_W'(want[k])) begin
            n_fail++;
            $display("FAIL rounding_%0d: got valid=%b data=%0d, want 1 %0d", prods[k], coef_valid, coef_data, want[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      coef_ready = 1'b0;
      send_n(N_TAPS, 1024);
      n_checks++;
      if (coef_valid !== 1'b1 || coef_data !== 11'sd1) begin
         n_fail++;
         $display("FAIL bp_first: got valid=%b data=%0d, want 1 1", coef_valid, coef_data);
      end
      for (int i = 0; i < N_TAPS - 1; i++) begin
         in_valid = 1'b1;
         in_prod  = PROD_W'(1024);
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_p%0d: got %b, want 1", N_TAPS + 1 + i, in_ready);
         end
         @(posedge clk);
         #1;
      end
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_stall: got in_ready=%b, want 0", in_ready);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (coef_valid !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_hold: got valid=%b busy=%b, want 1 1", coef_valid, busy);
      end
      coef_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: got in_ready=%b, want 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if (coef_valid !== 1'b1 || coef_data !== 11'sd1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_reload: got valid=%b data=%0d busy=%b, want 1 1 0", coef_valid, coef_data, busy);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (coef_valid !== 1'b0 || coef_data !== 11'sd1) begin
         n_fail++;
         $display("FAIL bp_drain_hold: got valid=%b data=%0d, want 0 1", coef_valid, coef_data);
      end
   endtask

   task automatic test_saturation();
      logic [OUT_W:0] hi_want;
      logic [OUT_W:0] lo_want;
`ifdef DCT_MAC_SAT_EN
      hi_want = {1'b1, 11'sd1023};
      lo_want = {1'b1, -11'sd1024};
`else
      hi_want = {1'b0, 11'sd0};
      lo_want = {1'b0, 11'sd0};
`endif
      do_reset();
      send_n(N_TAPS, 8388607);
      n_checks++;
      if ({coef_sat, coef_data} !== hi_want || coef_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_pos: got valid=%b sat=%b data=%0d, want sat/data %h", coef_valid, coef_sat, coef_data, hi_want);
      end
      send_n(N_TAPS, -8388608);
      n_checks++;
      if ({coef_sat, coef_data} !== lo_want || coef_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_neg: got valid=%b sat=%b data=%0d, want sat/data %h", coef_valid, coef_sat, coef_data, lo_want);
      end
      send_n(N_TAPS, 1024);
      n_checks++;
      if (coef_sat !== 1'b0 || coef_data !== 11'sd1) begin
         n_fail++;
         $display("FAIL sat_clear: got sat=%b data=%0d, want 0 1", coef_sat, coef_data);
      end
   endtask

   task automatic test_clear();
      do_reset();
      send_n(5, 1024);
      acc_clr  = 1'b1;
      in_valid = 1'b1;
      in_prod  = PROD_W'(2048);
      @(posedge clk);
      #1;
      acc_clr  = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (coef_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_restart: got valid=%b busy=%b, want 0 1", coef_valid, busy);
      end
      send_n(N_TAPS - 2, 1024);
      n_checks++;
      if (coef_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_discard: got valid=%b, want 0", coef_valid);
      end
      send_n(1, 1024);
      n_checks++;
      if (coef_valid !== 1'b1 || coef_data !== 11'sd1) begin
         n_fail++;
         $display("FAIL clr_coef: got valid=%b data=%0d, want 1 1", coef_valid, coef_data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      coef_ready = 1'b0;
      send_n(N_TAPS, 8192);
      send_n(3, 1024);
      rst = 1'b0;
      #1;
      n_checks++;
      if ({coef_valid, coef_sat, busy} !== 3'b000 || coef_data !== '0) begin
         n_fail++;
         $display("FAIL rstmid_async: got valid=%b sat=%b busy=%b data=%0d, want all 0", coef_valid, coef_sat, busy, coef_data);
      end
      @(posedge clk);
      #1;
      rst        = 1'b1;
      coef_ready = 1'b1;
      send_n(5, 8192);
      n_checks++;
      if (coef_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_discard: got valid=%b, want 0", coef_valid);
      end
      send_n(N_TAPS - 5, 8192);
      n_checks++;
      if (coef_valid !== 1'b1 || coef_data !== 11'sd8) begin
         n_fail++;
         $display("FAIL rstmid_coef: got valid=%b data=%0d, want 1 8", coef_valid, coef_data);
      end
   endtask

   task automatic test_random();
      int             grp[$];
      logic [OUT_W:0] outq[$];
      int             p;
      bit             v;
      bit             rdy;
      bit             clr;
      bit             exp_ready;
      longint         s;
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         v   = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         clr = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 1) == 1)
            p = int'($urandom_range(0, (1 << PROD_W) - 1)) - (1 << (PROD_W - 1));
         else
            p = int'($urandom_range(0, 131071)) - 65536;
         in_valid   = v;
         in_prod    = PROD_W'(p);
         coef_ready = rdy;
         acc_clr    = clr;
         #1;
         exp_ready = !(grp.size() == N_TAPS - 1 && outq.size() != 0 && !rdy);
         n_checks++;
         if (in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL rand_ready cyc %0d: got %b, want %b", cyc, in_ready, exp_ready);
         end
         n_checks++;
         if (coef_valid !== (outq.size() != 0) || busy !== (grp.size() != 0)) begin
            n_fail++;
            $display("FAIL rand_flags cyc %0d: got valid=%b busy=%b, want %b %b", cyc, coef_valid, busy, outq.size() != 0, grp.size() != 0);
         end
         if (outq.size() != 0) begin
            n_checks++;
            if ({coef_sat, coef_data} !== outq[0]) begin
               n_fail++;
               $display("FAIL rand_coef cyc %0d: got sat=%b data=%0d, want sat/data %h", cyc, coef_sat, coef_data, outq[0]);
            end
            if (rdy) void'(outq.pop_front());
         end
         if (clr) grp.delete();
         if (v && exp_ready) begin
            grp.push_back(p);
            if (grp.size() == N_TAPS) begin
               s = 0;
               foreach (grp[i]) s += longint'(grp[i]);
               outq.push_back(ref_coef(s));
               grp.delete();
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      acc_clr  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_back_to_back();
      test_saturation();
      test_clear();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dct_mac_acc.md
Name: dct_mac_acc

Overview:
- Accumulator stage directly downstream of the macu product register (mult_res) in each dct_unit of fdct_zigzag.dct_mod.
- Sums N_TAPS signed products into one 1-D DCT coefficient.
- Rounds, shifts and optionally saturates the sum, then presents it through a valid/ready output register that feeds the next DCT pass or the zigzag buffer.

Parameters:
- PROD_W, 24: signed width of the incoming product (mult_res).
- N_TAPS, 8: products summed per coefficient. Must be ≥ 2.
- FRAC_SHIFT, 13: fractional bits of the cosine constants, removed after accumulation. Must be ≥ 1.
- OUT_W, 11: signed width of the output coefficient.
- ACC_W, PROD_W+$clog2(N_TAPS): accumulator width. Derived; do not override.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: asynchronous, active-low reset (0 = reset).
- in_valid, input, 1: product valid.
- in_ready, output, 1: product accepted when in_valid & in_ready.
- in_prod, input, PROD_W: signed product (mult_res).
- acc_clr, input, 1: synchronous discard of the partial sum.
- coef_valid, output, 1: coefficient available.
- coef_ready, input, 1: consumer accepts the coefficient.
- coef_data, output, OUT_W: signed rounded coefficient.
- coef_sat, output, 1: coef_data was clamped (see Optional Feature).
- busy, output, 1: partial accumulation in progress (cnt != 0).

Behaviour:
- Reset state: acc=0, cnt=0, coef_valid=0, coef_data=0, coef_sat=0, busy=0. Reset mid-accumulation discards the partial sum, with no output.
- Counter: cnt runs 0..N_TAPS-1 and advances on each accepted product.
  - If cnt==0, acc <= sext(in_prod); otherwise acc <= acc + sext(in_prod).
  - Wrap-around: after the product accepted at cnt==N_TAPS-1, cnt returns to 0.
- Final product (accepted at cnt==N_TAPS-1): sum = acc + sext(in_prod).
  - r = (sum + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, arithmetic shift, i.e. round half toward +inf.
  - r is reduced to OUT_W bits and loaded into coef_data.
  - coef_valid=1 on the next cycle. Latency is 1 cycle from the last accepted product.
- Output register: holds coef_data and coef_valid until the cycle where coef_valid & coef_ready, then clears coef_valid. coef_data is held, not cleared.
- in_ready = !(cnt==N_TAPS-1 && coef_valid && !coef_ready).
  - Only the final product stalls.
  - Products 0..N_TAPS-2 are always accepted, even while the output is blocked.
- Simultaneous events:
  - Output drain and a new final product in the same cycle: the register reloads and coef_valid stays 1, so no bubble.
  - acc_clr together with a handshake: clear wins over the old sum. The accepted product is treated as cnt==0, giving cnt=1 and acc=sext(in_prod).
  - acc_clr never affects coef_valid, coef_data or coef_sat.
  - acc_clr at cnt==N_TAPS-1 with a pending stall: the stall releases, since cnt becomes 0 or 1.
- Width: accumulation is exact in ACC_W bits, with no internal overflow for N_TAPS full-scale products.

Optional Feature:
- Macro: DCT_MAC_SAT_EN.
- Defined:
  - r is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - coef_sat=1 with a clamped result; otherwise 0. It is registered with coef_data.
- Undefined:
  - r is truncated to its low OUT_W bits (two's-complement wrap).
  - coef_sat is tied to 0.
  - No clamp logic is synthesised.

Decomposition:
- Package dct_mac_pkg:
  - default widths: PROD_W, OUT_W, FRAC_SHIFT, N_TAPS;
  - rounding constant localparam;
  - function for the clog2-derived ACC_W.
- Sub-module dct_round_sat (combinational): sum to r, with the clamp and sat flag under DCT_MAC_SAT_EN.
- Counter, accumulator and output register stay in dct_mac_acc.

Test Plan:
- Basic sum: reset, then 8 products of 1024 with coef_ready=1 -> coef_valid exactly one cycle after the 8th, coef_data=1 (8192 rounds to 1), busy drops to 0.
- Rounding: 8 products of 512 (sum 4096) -> coef_data=1. Then 7 products of -512 plus one of -512 (sum -4096) -> coef_data=0, half rounds toward +inf. 8 products of 4096 (sum 32768) -> 4.
- Backpressure: coef_ready=0 and two full groups of 1024 -> first coef held. in_ready=1 for products 9..15 and 0 at the 16th. coef_ready=1 for one cycle -> 16th product accepted the same cycle, coef_valid stays 1, second coef=1.
- Saturation: 8 products of 8388607 (r=8192). With DCT_MAC_SAT_EN -> coef_data=1023, coef_sat=1. Without -> coef_data=0, coef_sat=0. Also 8 products of -8388608 with the macro -> -1024, coef_sat=1.
- Clear: 5 products of 1024, then acc_clr together with a product of 2048, then 7 products of 1024 -> coef_data=1 (sum 9216 rounds to 1), no output produced from the discarded 5.
- Reset mid-op: rst=0 after 3 products -> all outputs 0 immediately (asynchronous). After release, 8 products of 8192 -> coef_data=8.
